// File: rtl/batcharger_pkg.sv
// Shared definitions for the battery-charger ADC sequencer: state encoding,
// analog mux channel codes and timing defaults.
package batcharger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_STORE   = 2'd3
    } seq_state_t;

    localparam logic [1:0] CH_T = 2'b00;
    localparam logic [1:0] CH_V = 2'b01;
    localparam logic [1:0] CH_I = 2'b10;
    localparam int         NUM_CH = 3;

    localparam int SETTLE_CYC_DEF  = 4;
    localparam int TIMEOUT_CYC_DEF = 64;
    localparam int SETTLE_W        = 4;
    localparam int TIMEOUT_W       = 8;

    // Cyclic successor T -> V -> I -> T; the unused code 2'b11 maps to T.
    function automatic logic [1:0] ch_after(input logic [1:0] ch);
        case (ch)
            CH_T:    return CH_V;
            CH_V:    return CH_I;
            default: return CH_T;
        endcase
    endfunction

endpackage

// File: rtl/batcharger_adc_sequencer_if.sv
// Controller/ADC-side signal bundle of the ADC sequencer; the sequencer
// connects through the master modport, its environment through slave.
interface batcharger_adc_sequencer_if;
    import batcharger_pkg::*;

    logic       en;
    logic       tmonen;
    logic       vmonen;
    logic       imonen;
    logic       adc_done;
    logic [7:0] adc_data;
    logic       adc_start;
    logic [1:0] adc_sel;
    logic [7:0] tbat;
    logic [7:0] vbat;
    logic [7:0] ibat;
    logic       vtok;
    logic       adc_err;

    modport master (
        input  en, tmonen, vmonen, imonen, adc_done, adc_data,
        output adc_start, adc_sel, tbat, vbat, ibat, vtok, adc_err
    );

    modport slave (
        output en, tmonen, vmonen, imonen, adc_done, adc_data,
        input  adc_start, adc_sel, tbat, vbat, ibat, vtok, adc_err
    );

endinterface

// File: rtl/batcharger_adc_rr.sv
// Round-robin channel picker: returns the first requesting channel strictly
// after cur_ch in T -> V -> I order (cur_ch itself is checked last).
module batcharger_adc_rr
    import batcharger_pkg::*;
(
    input  logic [1:0] cur_ch,
    input  logic [2:0] req,
    output logic [1:0] next_ch,
    output logic       any_req
);

    logic [1:0]        cand [NUM_CH];
    logic [NUM_CH-1:0] cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cand
            if (gi == 0) begin : g_first
                assign cand[gi] = ch_after(cur_ch);
            end else begin : g_rest
                assign cand[gi] = ch_after(cand[gi-1]);
            end
            assign cand_hit[gi] = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        next_ch = CH_T;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                next_ch = cand[i];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/batcharger_adc_sequencer.sv
// Cycles the SAR ADC over the enabled charger monitor channels, latching
// each result into its channel register and flagging conversion timeouts.
module batcharger_adc_sequencer
    import batcharger_pkg::*;
#(
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                              clk,
    input  logic                              rstz,
    batcharger_adc_sequencer_if.master        bus,
    inout  wire                               dvdd,
    inout  wire                               dgnd
);

    localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST    = TIMEOUT_W'(TIMEOUT_CYC - 1);

    seq_state_t             state_reg, state_next;
    logic [1:0]             sel_reg, sel_next;
    logic [SETTLE_W-1:0]    settle_cnt_reg, settle_cnt_next;
    logic [TIMEOUT_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic                   start_reg, start_next;
    logic [7:0]             data_reg  [NUM_CH];
    logic [7:0]             data_next [NUM_CH];
    logic [NUM_CH-1:0]      valid_reg, valid_next;
    logic                   discard_reg, discard_next;
    logic                   err_reg, err_next;
    logic                   vtok_reg, vtok_next;

    logic [NUM_CH-1:0]      mon;
    logic [NUM_CH-1:0]      sel_onehot;
    logic                   sel_mon;
    logic [1:0]             rr_cur;
    logic [1:0]             rr_next;
    logic                   rr_any;
    wire                    unused_supply;

    assign unused_supply = dvdd ^ dgnd;
    assign mon           = {bus.imonen, bus.vmonen, bus.tmonen};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_sel
            assign sel_onehot[gi] = (sel_reg == 2'(gi));
        end
    endgenerate

    assign sel_mon = |(sel_onehot & mon);

    // Starting the search after I makes IDLE pick the first channel in T, V, I order.
    assign rr_cur = (state_reg == ST_STORE) ? sel_reg : CH_I;

    batcharger_adc_rr u_rr (
        .cur_ch  (rr_cur),
        .req     (mon),
        .next_ch (rr_next),
        .any_req (rr_any)
    );

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        settle_cnt_next = settle_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        start_next      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            data_next[i] = data_reg[i];
        end
        valid_next      = valid_reg & mon;
        discard_next    = discard_reg;
        err_next        = err_reg;
        vtok_next       = valid_reg[CH_T] & valid_reg[CH_V] & bus.tmonen & bus.vmonen;

        case (state_reg)
            ST_IDLE: begin
                if (rr_any) begin
                    state_next      = ST_SETTLE;
                    sel_next        = rr_next;
                    settle_cnt_next = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next   = ST_CONVERT;
                    start_next   = 1'b1;
                    tmo_cnt_next = '0;
                    discard_next = 1'b0;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            ST_CONVERT: begin
                tmo_cnt_next = (tmo_cnt_reg == '1) ? tmo_cnt_reg : tmo_cnt_reg + 1'b1;
                // Any monen drop during the conversion poisons its result.
                discard_next = discard_reg | ~sel_mon;
                if ((tmo_cnt_reg != '0) && bus.adc_done) begin
                    state_next = ST_STORE;
                    if (sel_mon && !discard_reg) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (sel_onehot[i]) begin
                                data_next[i]  = bus.adc_data;
                                valid_next[i] = 1'b1;
                            end
                        end
                    end
                end else if (tmo_cnt_reg >= TMO_LAST) begin
                    state_next = ST_STORE;
                    err_next   = 1'b1;
                end
            end
            ST_STORE: begin
                if (rr_any) begin
                    state_next      = ST_SETTLE;
                    sel_next        = rr_next;
                    settle_cnt_next = '0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (!bus.en) begin
            state_next = ST_IDLE;
            start_next = 1'b0;
            valid_next = '0;
            err_next   = 1'b0;
            vtok_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            state_reg      <= ST_IDLE;
            sel_reg        <= CH_T;
            settle_cnt_reg <= '0;
            tmo_cnt_reg    <= '0;
            start_reg      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                data_reg[i] <= '0;
            end
            valid_reg      <= '0;
            discard_reg    <= 1'b0;
            err_reg        <= 1'b0;
            vtok_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            settle_cnt_reg <= settle_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            start_reg      <= start_next;
            for (int i = 0; i < NUM_CH; i++) begin
                data_reg[i] <= data_next[i];
            end
            valid_reg      <= valid_next;
            discard_reg    <= discard_next;
            err_reg        <= err_next;
            vtok_reg       <= vtok_next;
        end
    end

    assign bus.adc_start = start_reg;
    assign bus.adc_sel   = sel_reg;
    assign bus.tbat      = data_reg[CH_T];
    assign bus.vbat      = data_reg[CH_V];
    assign bus.ibat      = data_reg[CH_I];
    assign bus.vtok      = vtok_reg;
    assign bus.adc_err   = err_reg;

endmodule

// File: tb/tb_batcharger_adc_sequencer.sv
// Scoreboarded bench for the ADC sequencer: expected channel order is queued
// per scenario and popped on every adc_start; a small ADC model answers starts.
module tb_batcharger_adc_sequencer;
    import batcharger_pkg::*;

    logic clk = 1'b0;
    logic rstz;
    wire  dvdd_w;
    wire  dgnd_w;
    assign dvdd_w = 1'b1;
    assign dgnd_w = 1'b0;

    batcharger_adc_sequencer_if bus ();

    batcharger_adc_sequencer #(
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk  (clk),
        .rstz (rstz),
        .bus  (bus),
        .dvdd (dvdd_w),
        .dgnd (dgnd_w)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         n_starts = 0;
    logic [1:0] exp_sel_q [$];
    logic       mdl_done = 1'b0;
    logic       man_done = 1'b0;
    logic [7:0] mdl_data = 8'h00;
    logic [7:0] man_data = 8'h00;
    logic       model_on = 1'b1;
    int         resp_dly  [4];
    logic [7:0] resp_data [4];

    assign bus.adc_done = mdl_done | man_done;
    assign bus.adc_data = man_done ? man_data : mdl_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int k = 0;
        while (n_starts < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val("wait_start", 32'(n_starts >= target), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Start monitor: every pulse pops the scoreboard and checks the mux select.
    initial forever begin
        @(posedge clk);
        #1;
        if (bus.adc_start === 1'b1) begin
            n_starts++;
            $display("start #%0d sel=%0d cyc=%0d", n_starts, bus.adc_sel, cyc);
            if (exp_sel_q.size() == 0) begin
                check_val("start_unexpected", 32'(exp_sel_q.size()), 1);
            end else begin
                check_val("start_sel", 32'(bus.adc_sel), 32'(exp_sel_q.pop_front()));
            end
        end
    end

    // ADC model: done pulse resp_dly cycles after the start cycle, 0 = never.
    initial begin
        logic [1:0] ch;
        forever begin
            @(posedge clk);
            #1;
            if (bus.adc_start === 1'b1 && model_on && resp_dly[bus.adc_sel] > 0) begin
                ch = bus.adc_sel;
                repeat (resp_dly[ch] + 1) @(negedge clk);
                mdl_data = resp_data[ch];
                mdl_done = 1'b1;
                $display("adc conv ch=%0d data=%02h", ch, resp_data[ch]);
                @(negedge clk);
                mdl_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int base;
        int k;

        rstz       = 1'b0;
        bus.en     = 1'b0;
        bus.tmonen = 1'b0;
        bus.vmonen = 1'b0;
        bus.imonen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            resp_dly[i]  = 0;
            resp_data[i] = 8'h00;
        end
        tick(2);
        check_val("rst_start", 32'(bus.adc_start), 0);
        check_val("rst_sel",   32'(bus.adc_sel), 0);
        check_val("rst_tbat",  32'(bus.tbat), 0);
        check_val("rst_vbat",  32'(bus.vbat), 0);
        check_val("rst_ibat",  32'(bus.ibat), 0);
        check_val("rst_vtok",  32'(bus.vtok), 0);
        check_val("rst_err",   32'(bus.adc_err), 0);
        rstz = 1'b1;
        tick(2);

        // Single temperature conversion
        resp_dly[0]  = 3;
        resp_data[0] = 8'h5A;
        exp_sel_q.push_back(CH_T);
        bus.en     = 1'b1;
        bus.tmonen = 1'b1;
        t0 = cyc;
        wait_starts(1, 20);
        check_val("t_start_lat", 32'(cyc - t0), 5);
        tick(4);
        check_val("t_tbat", 32'(bus.tbat), 'h5A);
        check_val("t_vtok", 32'(bus.vtok), 0);
        bus.en = 1'b0;
        tick(1);
        check_val("t_en0_hold", 32'(bus.tbat), 'h5A);
        tick(4);

        // Temperature + voltage alternation, vtok follows vbat load
        resp_dly[0]  = 3;
        resp_data[0] = 8'h60;
        resp_dly[1]  = 3;
        resp_data[1] = 8'h93;
        exp_sel_q.push_back(CH_T);
        exp_sel_q.push_back(CH_V);
        exp_sel_q.push_back(CH_T);
        exp_sel_q.push_back(CH_V);
        base = n_starts;
        bus.vmonen = 1'b1;
        bus.en     = 1'b1;
        k = 0;
        while (bus.vbat !== 8'h93 && k < 80) begin
            tick(1);
            k++;
        end
        check_val("tv_vbat", 32'(bus.vbat), 'h93);
        check_val("tv_tbat", 32'(bus.tbat), 'h60);
        check_val("tv_vtok_pre", 32'(bus.vtok), 0);
        tick(1);
        check_val("tv_vtok", 32'(bus.vtok), 1);
        wait_starts(base + 4, 60);
        bus.en = 1'b0;
        tick(10);

        // No adc_done at all: timeout, move to voltage
        for (int i = 0; i < 4; i++) begin
            resp_dly[i] = 0;
        end
        bus.imonen = 1'b1;
        exp_sel_q.push_back(CH_T);
        exp_sel_q.push_back(CH_V);
        base = n_starts;
        bus.en = 1'b1;
        wait_starts(base + 1, 20);
        t0 = cyc;
        k = 0;
        while (bus.adc_err !== 1'b1 && k < 100) begin
            tick(1);
            k++;
        end
        check_val("to_err_lat", 32'(cyc - t0), 64);
        check_val("to_err", 32'(bus.adc_err), 1);
        check_val("to_tbat", 32'(bus.tbat), 'h60);
        check_val("to_vbat", 32'(bus.vbat), 'h93);
        check_val("to_ibat", 32'(bus.ibat), 0);
        tick(1);
        check_val("to_next_sel", 32'(bus.adc_sel), 32'(CH_V));
        wait_starts(base + 2, 20);
        check_val("to_err_sticky", 32'(bus.adc_err), 1);
        bus.en = 1'b0;
        tick(1);
        check_val("to_err_clr", 32'(bus.adc_err), 0);
        tick(4);

        // vmonen drops during the voltage conversion
        bus.imonen   = 1'b0;
        resp_dly[0]  = 3;
        resp_data[0] = 8'h11;
        resp_dly[1]  = 6;
        resp_data[1] = 8'hC0;
        exp_sel_q.push_back(CH_T);
        exp_sel_q.push_back(CH_V);
        exp_sel_q.push_back(CH_T);
        base = n_starts;
        bus.en = 1'b1;
        wait_starts(base + 2, 40);
        tick(2);
        bus.vmonen = 1'b0;
        wait_starts(base + 3, 40);
        check_val("vd_vbat", 32'(bus.vbat), 'h93);
        check_val("vd_tbat", 32'(bus.tbat), 'h11);
        check_val("vd_vtok", 32'(bus.vtok), 0);
        check_val("vd_sel",  32'(bus.adc_sel), 32'(CH_T));
        bus.en = 1'b0;
        tick(8);

        // en dropped mid-SETTLE: no start, registers held
        bus.vmonen = 1'b1;
        base = n_starts;
        bus.en = 1'b1;
        tick(2);
        bus.en = 1'b0;
        tick(12);
        check_val("es_no_start", 32'(n_starts), 32'(base));
        check_val("es_vtok", 32'(bus.vtok), 0);
        check_val("es_tbat", 32'(bus.tbat), 'h11);
        check_val("es_vbat", 32'(bus.vbat), 'h93);

        // Reset during CONVERT, stale adc_done afterwards
        model_on   = 1'b0;
        bus.vmonen = 1'b0;
        exp_sel_q.push_back(CH_T);
        exp_sel_q.push_back(CH_T);
        base = n_starts;
        bus.en = 1'b1;
        wait_starts(base + 1, 20);
        tick(1);
        rstz = 1'b0;
        tick(1);
        check_val("rc_start", 32'(bus.adc_start), 0);
        check_val("rc_sel",   32'(bus.adc_sel), 0);
        check_val("rc_tbat",  32'(bus.tbat), 0);
        check_val("rc_vbat",  32'(bus.vbat), 0);
        check_val("rc_ibat",  32'(bus.ibat), 0);
        check_val("rc_vtok",  32'(bus.vtok), 0);
        check_val("rc_err",   32'(bus.adc_err), 0);
        rstz     = 1'b1;
        man_data = 8'hFF;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        check_val("rc_done_ign", 32'(bus.tbat), 0);
        wait_starts(base + 2, 20);
        tick(3);
        check_val("rc_tbat_after", 32'(bus.tbat), 0);
        bus.en = 1'b0;
        tick(2);
        check_val("sb_empty", 32'(exp_sel_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/batcharger_adc_sequencer.md
BATCHARGER_ADC_SEQUENCER -- requirements
Module: batcharger_adc_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 4: mux settle cycles before each conversion start, range 1..15.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64: maximum cycles to wait for adc_done, range 2..255.
REQ-003 SHALL have one clock and a synchronous, active-low reset, named as follows.
- clk  in  1  state machine clock
- rstz  in  1  synchronous active-low reset
REQ-004 SHALL provide the following ports.
- en  in  1  enables the sequencer
- tmonen  in  1  temperature channel request, from the charger controller
- vmonen  in  1  voltage channel request
- imonen  in  1  current channel request
- adc_done  in  1  SAR conversion complete
- adc_data  in  8  SAR result, valid while adc_done=1
- adc_start  out  1  one-cycle conversion start pulse
- adc_sel  out  2  analog mux select: 00 temp, 01 volt, 10 current
- tbat  out  8  latched temperature code
- vbat  out  8  latched voltage code
- ibat  out  8  latched current code
- vtok  out  1  voltage and temperature values valid
- adc_err  out  1  sticky conversion-timeout flag
- dvdd  inout  1  digital supply, no logic
- dgnd  inout  1  digital ground, no logic

Function
REQ-005 SHALL implement the FSM states IDLE, SETTLE, CONVERT and STORE.
REQ-006 IDLE SHALL move to SETTLE when en=1 and at least one monen is high, selecting the first enabled channel in the order T, V, I; otherwise it SHALL stay in IDLE.
REQ-007 SETTLE SHALL drive adc_sel, count SETTLE_CYC cycles, then go to CONVERT.
REQ-008 On the first CONVERT cycle, adc_start SHALL be 1 for exactly one cycle; adc_done SHALL be ignored in that cycle.
REQ-009 On the clock edge where adc_done=1 is sampled in CONVERT, the selected channel register SHALL load adc_data, its valid bit SHALL set, and the FSM SHALL go to STORE.
REQ-010 If adc_done is not seen within TIMEOUT_CYC cycles after the start pulse, the FSM SHALL set adc_err, leave the register unchanged, and go to STORE.
REQ-011 STORE SHALL last one cycle, then pick the next enabled channel cyclically after the current one (T->V->I->T) and go to SETTLE; if no channel is enabled it SHALL go to IDLE.
REQ-012 adc_sel SHALL remain stable from SETTLE entry through STORE.
REQ-013 If a channel's monen falls mid-conversion, the conversion SHALL complete, but its result SHALL be discarded and its valid bit cleared.
REQ-014 A channel's valid bit SHALL clear on the cycle after its monen is sampled low.
REQ-015 vtok SHALL be registered and equal (tvalid & vvalid & tmonen & vmonen).
REQ-016 en=0 SHALL force IDLE on the next edge, clear all valid bits and adc_err, and hold tbat/vbat/ibat at their values.
REQ-017 adc_done outside CONVERT SHALL be ignored.
REQ-018 The timeout counter SHALL saturate and SHALL never wrap.

Reset
REQ-019 With rstz=0 at a clk edge, the block SHALL enter IDLE with adc_start=0, adc_sel=00, tbat=vbat=ibat=0, vtok=0, adc_err=0, all valid bits 0 and all counters 0.
REQ-020 Reset mid-conversion SHALL abandon the conversion without producing an adc_start pulse.

Structure
REQ-021 The shared package batcharger_pkg SHALL hold the state encoding, the channel codes (CH_T=2'b00, CH_V=2'b01, CH_I=2'b10) and the SETTLE_CYC/TIMEOUT_CYC defaults.
REQ-022 The round-robin next-channel picker SHALL be one sub-module, batcharger_adc_rr (inputs: current channel, 3 request bits; outputs: next channel, any-request flag).

Verification
REQ-023 With en=1, tmonen=1, and adc_done returned 3 cycles after start with data 0x5A, the bench SHALL see adc_start at cycle 5 after en, adc_sel=00, tbat=0x5A, and vtok=0.
REQ-024 With tmonen=vmonen=1 and data T=0x60, V=0x93, the bench SHALL see the channel sequence 00,01,00,01 and vtok=1 one cycle after vbat=0x93 loads.
REQ-025 With all monen high and adc_done never asserted, the bench SHALL see adc_err=1 at start+64 cycles, the next channel 01 selected, and the registers unchanged.
REQ-026 When vmonen drops during a V conversion returning 0xC0, the bench SHALL see vbat not updated, vtok=0, and the next channel 00.
REQ-027 With en dropped mid-SETTLE, the bench SHALL see IDLE next cycle, no adc_start pulse, and vtok=0 with the registers held.
REQ-028 With rstz=0 for one edge during CONVERT, the bench SHALL see all outputs at their reset values and adc_done=1 on the following cycle ignored.
